oddr_tx_link_ctrl: RTL and testbench

Startup and recovery sequencer for the 4-lane DDR x4 transmit gearing path (gearing FIFO plus DDR x2 output stage).
- Waits for a stable PLL lock, then holds the gearing reset for a fixed time.
- Releases the reset, enables the high-speed clock-enable and waits for the output stage ready.
- Declares the link up once ready arrives; retries on timeout and recovers on lock or ready loss.
- Sits in the clk_s domain, between link-level control and the gearing/DDR datapath.

---
 rtl/oddr_tx_link_ctrl.sv | 157 +++++++++++++++
 tb/tb_oddr_tx_link_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/oddr_tx_link_ctrl.sv
// Startup/recovery sequencer for the 4-lane DDR x4 transmit gearing path:
// waits for stable PLL lock, sequences gear_reset/hsxx_clk_en, retries on ready timeout.
module oddr_tx_link_ctrl #(
  parameter int LOCK_STABLE_CYC   = 16,
  parameter int RESET_HOLD_CYC    = 8,
  parameter int READY_TIMEOUT_CYC = 64,
  parameter int MAX_RETRY         = 2
) (
  input  logic                               clk_s,
  input  logic                               reset,
  input  logic                               start_req,
  input  logic                               lock_chk,
  input  logic                               tx_ready,
  output logic                               gear_reset,
  output logic                               hsxx_clk_en,
  output logic                               link_up,
  output logic                               fail,
  output logic [$clog2(MAX_RETRY+1)-1:0]     retry_cnt,
  output logic [2:0]                         state_o
);

  localparam int CYC_MAX_A = (LOCK_STABLE_CYC > RESET_HOLD_CYC) ? LOCK_STABLE_CYC : RESET_HOLD_CYC;
  localparam int CYC_MAX   = (CYC_MAX_A > READY_TIMEOUT_CYC) ? CYC_MAX_A : READY_TIMEOUT_CYC;
  localparam int CNT_W     = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;
  localparam int RC_W      = $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(RESET_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(READY_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};
  localparam logic [RC_W-1:0]  RETRY_LAST = RC_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_LOCK  = 3'd1,
    S_RST_HOLD   = 3'd2,
    S_WAIT_READY = 3'd3,
    S_RUN        = 3'd4,
    S_FAIL       = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RC_W-1:0]   retry_q, retry_d;
  logic              gear_reset_q, gear_reset_d;
  logic              hsxx_clk_en_q, hsxx_clk_en_d;
  logic              link_up_q, link_up_d;
  logic              fail_q, fail_d;
  logic              lock_meta_q, lock_s_q;
  logic              ready_meta_q, ready_s_q;

  // Two-flop synchronisers for the asynchronous lock and ready inputs
  always_ff @(posedge clk_s or posedge reset) begin
    if (reset) begin
      lock_meta_q  <= 1'b0;
      lock_s_q     <= 1'b0;
      ready_meta_q <= 1'b0;
      ready_s_q    <= 1'b0;
    end else begin
      lock_meta_q  <= lock_chk;
      lock_s_q     <= lock_meta_q;
      ready_meta_q <= tx_ready;
      ready_s_q    <= ready_meta_q;
    end
  end

  always_ff @(posedge clk_s or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      retry_q       <= '0;
      gear_reset_q  <= 1'b1;
      hsxx_clk_en_q <= 1'b0;
      link_up_q     <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_q       <= retry_d;
      gear_reset_q  <= gear_reset_d;
      hsxx_clk_en_q <= hsxx_clk_en_d;
      link_up_q     <= link_up_d;
      fail_q        <= fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    if (!start_req) begin
      state_d = S_IDLE;
      retry_d = '0;
    end else if (!lock_s_q &&
                 (state_q == S_RST_HOLD || state_q == S_WAIT_READY || state_q == S_RUN)) begin
      state_d = S_WAIT_LOCK;
      retry_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          // Any unlocked cycle restarts the stability window
          if (!lock_s_q)              cnt_d   = '0;
          else if (cnt_q == LOCK_LAST) state_d = S_RST_HOLD;
        end
        S_RST_HOLD: begin
          if (cnt_q == HOLD_LAST) state_d = S_WAIT_READY;
        end
        S_WAIT_READY: begin
          if (ready_s_q) begin
            state_d = S_RUN;
          end else if (cnt_q == TO_LAST) begin
            if (retry_q == RETRY_LAST) begin
              state_d = S_FAIL;
            end else begin
              state_d = S_RST_HOLD;
              retry_d = retry_q + 1'b1;
            end
          end
        end
        S_RUN: begin
          cnt_d = '0;
          // A lost ready starts a fresh attempt rather than consuming a retry
          if (!ready_s_q) begin
            state_d = S_RST_HOLD;
            retry_d = '0;
          end
        end
        S_FAIL: begin
          cnt_d = '0;
        end
        default: begin
          state_d = S_IDLE;
          retry_d = '0;
        end
      endcase
    end

    if (state_d == S_IDLE || state_d != state_q) cnt_d = '0;

    hsxx_clk_en_d = (state_d == S_WAIT_READY) || (state_d == S_RUN);
    gear_reset_d  = !hsxx_clk_en_d;
    link_up_d     = (state_d == S_RUN);
    fail_d        = (state_d == S_FAIL);
  end

  assign gear_reset  = gear_reset_q;
  assign hsxx_clk_en = hsxx_clk_en_q;
  assign link_up     = link_up_q;
  assign fail        = fail_q;
  assign retry_cnt   = retry_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_oddr_tx_link_ctrl.sv
// Directed testbench for oddr_tx_link_ctrl: bring-up, lock glitch, retries,
// fail, loss recovery and asynchronous reset.
module tb_oddr_tx_link_ctrl;

  logic       clk_s;
  logic       reset;
  logic       start_req;
  logic       lock_chk;
  logic       tx_ready;
  logic       gear_reset;
  logic       hsxx_clk_en;
  logic       link_up;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;

  oddr_tx_link_ctrl #(
    .LOCK_STABLE_CYC(16),
    .RESET_HOLD_CYC(8),
    .READY_TIMEOUT_CYC(64),
    .MAX_RETRY(2)
  ) dut (
    .clk_s(clk_s),
    .reset(reset),
    .start_req(start_req),
    .lock_chk(lock_chk),
    .tx_ready(tx_ready),
    .gear_reset(gear_reset),
    .hsxx_clk_en(hsxx_clk_en),
    .link_up(link_up),
    .fail(fail),
    .retry_cnt(retry_cnt),
    .state_o(state_o)
  );

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;

  // gear_reset and hsxx_clk_en must never be high together
  always @(negedge clk_s) begin
    checks++;
    if (gear_reset === 1'b1 && hsxx_clk_en === 1'b1) begin
      errors++;
      $display("FAIL invariant: gear_reset=%b hsxx_clk_en=%b expected not both 1", gear_reset, hsxx_clk_en);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_s);
      #1;
    end
  endtask

  // Reset with lock already high, then let the synchroniser settle while idle
  task automatic do_reset(input logic rdy);
    reset     = 1'b1;
    start_req = 1'b0;
    lock_chk  = 1'b1;
    tx_ready  = rdy;
    step(2);
    reset = 1'b0;
    step(3);
  endtask

  task automatic test_reset;
    reset = 1'b1; start_req = 1'b0; lock_chk = 1'b0; tx_ready = 1'b0;
    step(2);
    checks++;
    if ({state_o, gear_reset, hsxx_clk_en, link_up, fail, retry_cnt} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}) begin
      errors++;
      $display("FAIL reset_vals: state=%0d gr=%b en=%b up=%b fail=%b rc=%0d expected 0 1 0 0 0 0",
               state_o, gear_reset, hsxx_clk_en, link_up, fail, retry_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_nominal;
    do_reset(1'b0);
    checks++;
    if (state_o !== 3'd0) begin errors++; $display("FAIL nom_idle: state=%0d expected 0", state_o); end
    start_req = 1'b1;
    step(1);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL nom_wait_lock: state=%0d expected 1", state_o); end
    step(15);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL nom_lock_c16: state=%0d expected 1", state_o); end
    step(1);
    checks++;
    if (state_o !== 3'd2 || gear_reset !== 1'b1) begin
      errors++; $display("FAIL nom_rst_hold_c17: state=%0d gr=%b expected 2 1", state_o, gear_reset);
    end
    step(7);
    checks++;
    if (state_o !== 3'd2 || gear_reset !== 1'b1 || hsxx_clk_en !== 1'b0) begin
      errors++; $display("FAIL nom_c24: state=%0d gr=%b en=%b expected 2 1 0", state_o, gear_reset, hsxx_clk_en);
    end
    step(1);
    checks++;
    if (state_o !== 3'd3 || gear_reset !== 1'b0 || hsxx_clk_en !== 1'b1) begin
      errors++; $display("FAIL nom_c25: state=%0d gr=%b en=%b expected 3 0 1", state_o, gear_reset, hsxx_clk_en);
    end
    step(9);
    tx_ready = 1'b1;
    step(2);
    checks++;
    if (state_o !== 3'd3 || link_up !== 1'b0) begin
      errors++; $display("FAIL nom_c36: state=%0d up=%b expected 3 0", state_o, link_up);
    end
    step(1);
    checks++;
    if (state_o !== 3'd4 || link_up !== 1'b1 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL nom_c37: state=%0d up=%b rc=%0d expected 4 1 0", state_o, link_up, retry_cnt);
    end
    $display("test_nominal done");
  endtask

  task automatic test_lock_glitch;
    do_reset(1'b0);
    start_req = 1'b1;
    step(1);
    step(9);
    lock_chk = 1'b0;
    step(1);
    lock_chk = 1'b1;
    step(17);
    checks++;
    if (state_o !== 3'd1) begin errors++; $display("FAIL glitch_still_lock: state=%0d expected 1", state_o); end
    step(1);
    checks++;
    if (state_o !== 3'd2) begin errors++; $display("FAIL glitch_rst_hold: state=%0d expected 2", state_o); end
    $display("test_lock_glitch done");
  endtask

  task automatic test_retry_then_success;
    do_reset(1'b0);
    start_req = 1'b1;
    step(25);
    step(63);
    checks++;
    if (state_o !== 3'd3 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL retry_pre_timeout: state=%0d rc=%0d expected 3 0", state_o, retry_cnt);
    end
    step(1);
    checks++;
    if (state_o !== 3'd2 || retry_cnt !== 2'd1 || gear_reset !== 1'b1 || hsxx_clk_en !== 1'b0) begin
      errors++; $display("FAIL retry_timeout: state=%0d rc=%0d gr=%b en=%b expected 2 1 1 0",
                         state_o, retry_cnt, gear_reset, hsxx_clk_en);
    end
    step(7);
    checks++;
    if (state_o !== 3'd2 || gear_reset !== 1'b1) begin
      errors++; $display("FAIL retry_hold8: state=%0d gr=%b expected 2 1", state_o, gear_reset);
    end
    step(1);
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL retry_wait2: state=%0d expected 3", state_o); end
    tx_ready = 1'b1;
    step(3);
    checks++;
    if (state_o !== 3'd4 || link_up !== 1'b1 || retry_cnt !== 2'd1) begin
      errors++; $display("FAIL retry_run: state=%0d up=%b rc=%0d expected 4 1 1", state_o, link_up, retry_cnt);
    end
    $display("test_retry_then_success done");
  endtask

  task automatic test_ready_loss;
    tx_ready = 1'b0;
    step(2);
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL rdyloss_sync: state=%0d expected 4", state_o); end
    step(1);
    checks++;
    if (state_o !== 3'd2 || retry_cnt !== 2'd0 || gear_reset !== 1'b1 || link_up !== 1'b0) begin
      errors++; $display("FAIL rdyloss: state=%0d rc=%0d gr=%b up=%b expected 2 0 1 0",
                         state_o, retry_cnt, gear_reset, link_up);
    end
    $display("test_ready_loss done");
  endtask

  task automatic test_exhausted;
    do_reset(1'b0);
    start_req = 1'b1;
    step(25);
    step(64);
    checks++;
    if (state_o !== 3'd2 || retry_cnt !== 2'd1) begin
      errors++; $display("FAIL exh_t1: state=%0d rc=%0d expected 2 1", state_o, retry_cnt);
    end
    step(8);
    step(64);
    checks++;
    if (state_o !== 3'd2 || retry_cnt !== 2'd2) begin
      errors++; $display("FAIL exh_t2: state=%0d rc=%0d expected 2 2", state_o, retry_cnt);
    end
    step(8);
    step(63);
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL exh_pre_t3: state=%0d expected 3", state_o); end
    step(1);
    checks++;
    if (state_o !== 3'd5 || fail !== 1'b1 || gear_reset !== 1'b1 || hsxx_clk_en !== 1'b0) begin
      errors++; $display("FAIL exh_fail: state=%0d fail=%b gr=%b en=%b expected 5 1 1 0",
                         state_o, fail, gear_reset, hsxx_clk_en);
    end
    tx_ready = 1'b1;
    step(6);
    checks++;
    if (state_o !== 3'd5 || fail !== 1'b1) begin
      errors++; $display("FAIL exh_sticky: state=%0d fail=%b expected 5 1", state_o, fail);
    end
    start_req = 1'b0;
    step(1);
    checks++;
    if (state_o !== 3'd0 || fail !== 1'b0 || retry_cnt !== 2'd0) begin
      errors++; $display("FAIL exh_idle: state=%0d fail=%b rc=%0d expected 0 0 0", state_o, fail, retry_cnt);
    end
    $display("test_exhausted done");
  endtask

  task automatic test_lock_loss;
    do_reset(1'b1);
    start_req = 1'b1;
    step(26);
    checks++;
    if (state_o !== 3'd4) begin errors++; $display("FAIL lockloss_run: state=%0d expected 4", state_o); end
    lock_chk = 1'b0;
    step(2);
    checks++;
    if (state_o !== 3'd4 || link_up !== 1'b1) begin
      errors++; $display("FAIL lockloss_sync: state=%0d up=%b expected 4 1", state_o, link_up);
    end
    step(1);
    checks++;
    if (state_o !== 3'd1 || link_up !== 1'b0 || hsxx_clk_en !== 1'b0 || gear_reset !== 1'b1) begin
      errors++; $display("FAIL lockloss: state=%0d up=%b en=%b gr=%b expected 1 0 0 1",
                         state_o, link_up, hsxx_clk_en, gear_reset);
    end
    $display("test_lock_loss done");
  endtask

  task automatic test_async_reset;
    do_reset(1'b0);
    start_req = 1'b1;
    step(30);
    checks++;
    if (state_o !== 3'd3) begin errors++; $display("FAIL arst_pre: state=%0d expected 3", state_o); end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (state_o !== 3'd0 || gear_reset !== 1'b1 || hsxx_clk_en !== 1'b0) begin
      errors++; $display("FAIL arst_immediate: state=%0d gr=%b en=%b expected 0 1 0",
                         state_o, gear_reset, hsxx_clk_en);
    end
    step(2);
    reset = 1'b0;
    $display("test_async_reset done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_lock_glitch();
    test_retry_then_success();
    test_ready_loss();
    test_exhausted();
    test_lock_loss();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
